mux_dm: RTL and testbench

- Writeback-select multiplexer for the RISC-V datapath; chooses one of three WIDTH-bit sources (A, B, C) or constant zero, driven by a 2-bit select.
- Sits between the ALU / data-memory / PC+4 sources and the register-file write port.
- Output is registered (one pipeline stage) with valid tracking and a sticky flag for the reserved select code.

---
 rtl/mux_dm_pkg.sv | 15 +
 rtl/mux_dm_core.sv | 30 +++
 rtl/mux_dm.sv | 73 +++++++
 tb/tb_mux_dm.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mux_dm_pkg.sv
// Shared types and constants for the writeback-select multiplexer.
package mux_dm_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned SEL_W         = 2;

  // Writeback source select; SEL_ZERO is reserved but legal (drives zero).
  typedef enum logic [SEL_W-1:0] {
    SEL_C    = 2'b00,
    SEL_B    = 2'b01,
    SEL_A    = 2'b10,
    SEL_ZERO = 2'b11
  } wb_sel_t;

endpackage : mux_dm_pkg

// File: rtl/mux_dm_core.sv
// Purely combinational 4:1 writeback select.
// Ports:
//   a, b, c : WIDTH-bit sources (A <- 2'b10, B <- 2'b01, C <- 2'b00)
//   sel     : source select; 2'b11 yields all-zeros
//   y       : selected value
module mux_dm_core
  import mux_dm_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  wb_sel_t          sel,
  output logic [WIDTH-1:0] y
);

  // Bitwise select, no conversion of the chosen source.
  always_comb begin
    y = '0;
    case (sel)
      SEL_C:    y = c;
      SEL_B:    y = b;
      SEL_A:    y = a;
      SEL_ZERO: y = '0;
      default:  y = '0;
    endcase
  end

endmodule : mux_dm_core

// File: rtl/mux_dm.sv
// Writeback-select multiplexer feeding the register-file write port.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   in_valid   : qualifies a, b, c, sel this cycle
//   a, b, c    : WIDTH-bit sources
//   sel        : 2-bit source select (2'b11 reserved -> zero, flagged)
//   err_clr    : clears sel_err (a simultaneous set wins)
//   result     : selected value (registered when REGISTERED=1)
//   out_valid  : result is valid (registered when REGISTERED=1)
//   sel_err    : sticky flag, reserved select accepted; always registered
module mux_dm
  import mux_dm_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter bit          REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [SEL_W-1:0] sel,
  input  logic             err_clr,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             sel_err
);

  logic [WIDTH-1:0] mux_y;

  mux_dm_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a   (a),
    .b   (b),
    .c   (c),
    .sel (wb_sel_t'(sel)),
    .y   (mux_y)
  );

  generate
    if (REGISTERED) begin : g_reg
      // One pipeline stage; result holds across invalid cycles.
      always_ff @(posedge clk) begin
        if (rst) begin
          result    <= '0;
          out_valid <= 1'b0;
        end else begin
          out_valid <= in_valid;
          if (in_valid) begin
            result <= mux_y;
          end
        end
      end
    end else begin : g_comb
      assign result    = mux_y;
      assign out_valid = in_valid;
    end
  endgenerate

  // Sticky reserved-select flag; set has priority over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (in_valid && (wb_sel_t'(sel) == SEL_ZERO)) begin
      sel_err <= 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end
  end

endmodule : mux_dm

// File: tb/tb_mux_dm.sv
// Scoreboard bench for mux_dm: a registered and a combinational instance
// share one stimulus stream and are checked against a behavioural model.
module tb_mux_dm;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a, b, c;
  logic [1:0]   sel;
  logic         err_clr;

  logic [W-1:0] r_result, c_result;
  logic         r_valid, c_valid;
  logic         r_err, c_err;

  int tests = 0;
  int fails = 0;

  // Model state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_hold;
  logic         exp_valid;
  logic         exp_err;
  bit           checking;

  always #5 clk = ~clk;

  mux_dm #(.WIDTH(W), .REGISTERED(1'b1)) dut_reg (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .sel(sel), .err_clr(err_clr), .result(r_result), .out_valid(r_valid),
    .sel_err(r_err)
  );

  mux_dm #(.WIDTH(W), .REGISTERED(1'b0)) dut_comb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .sel(sel), .err_clr(err_clr), .result(c_result), .out_valid(c_valid),
    .sel_err(c_err)
  );

  // Writeback choice as a lookup over the select code.
  function automatic logic [W-1:0] pick(input logic [W-1:0] sa, sb, sc,
                                         input logic [1:0] s);
    logic [W-1:0] src [4];
    src[0] = sc;
    src[1] = sb;
    src[2] = sa;
    src[3] = '0;
    return src[s];
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and advance the model at the edge.
  task automatic drive(input logic r, input logic v, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic [W-1:0] ic,
                       input logic [1:0] s, input logic ec);
    logic [W-1:0] val;
    rst = r; in_valid = v; a = ia; b = ib; c = ic; sel = s; err_clr = ec;
    @(posedge clk);
    if (r) begin
      exp_valid = 1'b0;
      exp_hold  = '0;
      exp_err   = 1'b0;
      exp_q.delete();
    end else begin
      exp_valid = v;
      if (v) begin
        val = pick(ia, ib, ic, s);
        exp_q.push_back(val);
        exp_hold = val;
      end
      if (v && s == 2'b11) exp_err = 1'b1;
      else if (ec)         exp_err = 1'b0;
    end
    checking = 1'b1;
    #1;
  endtask

  // Monitor: sample both instances mid-cycle.
  always @(negedge clk) begin
    if (checking) begin
      chk("reg_out_valid", W'(r_valid), W'(exp_valid));
      if (r_valid) begin
        if (exp_q.size() == 0) begin
          chk("reg_unexpected_output", W'(1), W'(0));
        end else begin
          chk("reg_result", r_result, exp_q.pop_front());
        end
      end else begin
        chk("reg_result_hold", r_result, exp_hold);
      end
      chk("reg_sel_err", W'(r_err), W'(exp_err));
      chk("comb_result", c_result, pick(a, b, c, sel));
      chk("comb_out_valid", W'(c_valid), W'(in_valid));
      chk("comb_sel_err", W'(c_err), W'(exp_err));
    end
  end

  initial begin
    checking = 1'b0;
    exp_hold = '0; exp_valid = 1'b0; exp_err = 1'b0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c = '0; sel = '0; err_clr = 1'b0;

    // Reset held with valid input present
    drive(1, 1, 32'h2, 32'h0, 32'h0, 2'b10, 0);
    drive(1, 1, 32'h2, 32'h0, 32'h0, 2'b10, 0);

    // Back-to-back selects
    drive(0, 1, 32'h2, 32'h0, 32'h0, 2'b10, 0);
    drive(0, 1, 32'h1, 32'h2, 32'h0, 2'b01, 0);
    drive(0, 1, 32'h1, 32'h2, 32'h3, 2'b00, 0);

    // Reserved code then clear
    drive(0, 1, 32'h3, 32'h3, 32'h3, 2'b11, 0);
    drive(0, 1, 32'h4, 32'h5, 32'h6, 2'b00, 1);

    // Hold with changing inputs, then set/clear collision
    drive(0, 0, 32'hAAAA, 32'hBBBB, 32'hCCCC, 2'b01, 0);
    drive(0, 0, 32'h1111, 32'h2222, 32'h3333, 2'b11, 0);
    drive(0, 1, 32'h7, 32'h8, 32'h9, 2'b11, 1);
    drive(0, 0, 32'h0, 32'h0, 32'h0, 2'b00, 0);

    // Combinational pass-through value
    drive(0, 1, 32'hDEADBEEF, 32'h0, 32'h0, 2'b10, 1);
    drive(0, 0, 32'hDEADBEEF, 32'h0, 32'h0, 2'b10, 0);

    // Reset mid-stream discards the pending output
    drive(0, 1, 32'h55, 32'h66, 32'h77, 2'b01, 0);
    drive(1, 1, 32'h55, 32'h66, 32'h77, 2'b11, 0);
    drive(0, 1, 32'h99, 32'h66, 32'h77, 2'b10, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) != 0),
            $urandom(), $urandom(), $urandom(),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 4) == 0));
    end

    drive(0, 0, '0, '0, '0, 2'b00, 0);
    @(negedge clk);
    checking = 1'b0;
    chk("scoreboard_drained", W'(exp_q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mux_dm
